acq_write_control: RTL and testbench

Parametrised multi-channel successor to the single-channel ADC write controller. Arms on software request, waits for a configurable trigger on one selected channel, then captures a runtime-programmable number of sample sets. Each set is serialised into one 64-bit FIFO word per channel, with `write_SRAM_en` pulsed once per `BURST` words. Sits between the ADC front end and the FIFO/SRAM writer.

---
 rtl/acq_pkg.sv | 30 +++
 rtl/acq_trig_detect.sv | 64 ++++++
 rtl/acq_write_control.sv | 229 ++++++++++++++++++++++
 tb/tb_acq_write_control.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// ---------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the multi-channel acquisition write controller:
// trigger-mode codes, FSM state encoding and data_out field offsets.
// ---------------------------------------------------------------------------
package acq_pkg;

    // Trigger modes, as presented on trig_mode
    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;
    localparam logic [1:0] TRIG_BOTH = 2'd3;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIGGER = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } acq_state_t;

    // data_out layout: {ts[31:0], ch[7:0], zero pad, sample}
    localparam int TS_MSB = 63;
    localparam int TS_LSB = 32;
    localparam int CH_MSB = 31;
    localparam int CH_LSB = 24;

endpackage

// File: rtl/acq_trig_detect.sv
// ---------------------------------------------------------------------------
// acq_trig_detect
// Edge/level trigger detector for the selected channel. Remembers the sample
// seen at the previous strobe (plus a valid flag) and raises fire for the
// strobe that satisfies the configured mode against the threshold.
//
// Ports
//   clk, rst   : clock, synchronous active-low reset
//   clear      : forget the previous sample (asserted when arming)
//   strobe     : one-cycle sample strobe while waiting for the trigger
//   mode       : TRIG_IMM / TRIG_RISE / TRIG_FALL / TRIG_BOTH
//   level      : unsigned threshold
//   sample     : current sample of the trigger channel
//   fire       : combinational, high only in the cycle of the firing strobe
// ---------------------------------------------------------------------------
module acq_trig_detect
    import acq_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              strobe,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] sample,
    output logic              fire
);

    logic [DATA_W-1:0] prev;
    logic              valid;
    logic              rise;
    logic              fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            prev  <= '0;
            valid <= 1'b0;
        end else if (strobe) begin
            prev  <= sample;
            valid <= 1'b1;
        end
    end

    // The first strobe after arming only primes prev, so edge modes need valid.
    always_comb begin
        rise = valid && (prev < level) && (sample >= level);
        fall = valid && (prev > level) && (sample <= level);
        fire = 1'b0;
        if (strobe) begin
            case (mode)
                TRIG_IMM:  fire = 1'b1;
                TRIG_RISE: fire = rise;
                TRIG_FALL: fire = fall;
                default:   fire = rise || fall;
            endcase
        end
    end

endmodule

// File: rtl/acq_write_control.sv
// ---------------------------------------------------------------------------
// acq_write_control
// Multi-channel ADC write controller. Arms on wr_en, waits for a trigger on
// one channel, then captures sample_count sample sets. Each set becomes one
// 64-bit FIFO word per channel; write_SRAM_en is pulsed every BURST words and
// once more at the end for a partial burst.
//
// Ports
//   clk, rst        : clock, synchronous active-low reset
//   wr_en           : software arm / acknowledge level
//   trig_mode       : trigger mode (latched at arm)
//   trig_ch         : trigger channel (latched at arm)
//   trig_level      : trigger threshold (latched at arm)
//   sample_count    : sets to capture (latched at arm)
//   new_data        : ADC data-valid level, rising edge = strobe
//   data_in         : channel c at [c*DATA_W +: DATA_W]
//   fifo_full       : FIFO backpressure
//   data_out        : {ts, ch, pad, sample}
//   write_fifo_en   : one-cycle FIFO write strobe
//   write_SRAM_en   : one-cycle SRAM write request
//   write_end       : capture complete, held until wr_en drops
//   overrun         : sticky, a strobe arrived while a set was being emitted
// ---------------------------------------------------------------------------
module acq_write_control
    import acq_pkg::*;
#(
    parameter  int DATA_W = 12,
    parameter  int N_CH   = 4,
    parameter  int TS_W   = 32,
    parameter  int BURST  = 4,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [1:0]             trig_mode,
    input  logic [CH_W-1:0]        trig_ch,
    input  logic [DATA_W-1:0]      trig_level,
    input  logic [CNT_W-1:0]       sample_count,
    input  logic                   new_data,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic                   fifo_full,
    output logic [63:0]            data_out,
    output logic                   write_fifo_en,
    output logic                   write_SRAM_en,
    output logic                   write_end,
    output logic                   overrun
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    acq_state_t state, state_d;

    logic                   new_data_q;
    logic                   strobe;
    logic [TS_W-1:0]        ts_q;

    logic [1:0]             mode_q;
    logic [CH_W-1:0]        trig_ch_q;
    logic [DATA_W-1:0]      level_q;
    logic [CNT_W-1:0]       count_q;

    logic [N_CH*DATA_W-1:0] snap_data;
    logic [TS_W-1:0]        snap_ts;
    logic [CH_W-1:0]        ch_idx;
    logic [CNT_W-1:0]       set_cnt;
    logic [CNT_W-1:0]       set_next;
    logic [BW-1:0]          burst_cnt;

    logic                   arm;
    logic                   take_set;
    logic                   emit;
    logic                   last_ch;
    logic                   det_strobe;
    logic                   fire;
    logic [63:0]            word;

    assign strobe   = new_data && !new_data_q;
    assign set_next = set_cnt + CNT_W'(1);

    acq_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk    (clk),
        .rst    (rst),
        .clear  (arm),
        .strobe (det_strobe),
        .mode   (mode_q),
        .level  (level_q),
        .sample (data_in[trig_ch_q*DATA_W +: DATA_W]),
        .fire   (fire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    // Next state and per-cycle actions
    always_comb begin
        state_d    = state;
        arm        = 1'b0;
        take_set   = 1'b0;
        emit       = 1'b0;
        last_ch    = 1'b0;
        det_strobe = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_en) begin
                    arm     = 1'b1;
                    state_d = (sample_count == '0) ? S_DONE : S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                det_strobe = strobe;
                if (!wr_en) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    take_set = 1'b1;
                    state_d  = S_EMIT;
                end
            end
            S_CAPTURE: begin
                if (!wr_en) begin
                    state_d = S_FLUSH;
                end else if (strobe) begin
                    take_set = 1'b1;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!fifo_full) begin
                    emit = 1'b1;
                    if (ch_idx == CH_W'(N_CH - 1)) begin
                        last_ch = 1'b1;
                        if ((set_next == count_q) || !wr_en) state_d = S_FLUSH;
                        else                                 state_d = S_CAPTURE;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE: begin
                if (!wr_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word for the channel currently being emitted
    always_comb begin
        word                 = '0;
        word[TS_MSB:TS_LSB]  = 32'(snap_ts);
        word[CH_MSB:CH_LSB]  = 8'(ch_idx);
        word[DATA_W-1:0]     = snap_data[ch_idx*DATA_W +: DATA_W];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            new_data_q    <= 1'b0;
            ts_q          <= '0;
            mode_q        <= TRIG_IMM;
            trig_ch_q     <= '0;
            level_q       <= '0;
            count_q       <= '0;
            snap_data     <= '0;
            snap_ts       <= '0;
            ch_idx        <= '0;
            set_cnt       <= '0;
            burst_cnt     <= '0;
            data_out      <= '0;
            write_fifo_en <= 1'b0;
            write_SRAM_en <= 1'b0;
            write_end     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            new_data_q    <= new_data;
            ts_q          <= ts_q + TS_W'(1);
            write_fifo_en <= 1'b0;
            write_SRAM_en <= 1'b0;
            write_end     <= (state_d == S_DONE);

            if (arm) begin
                mode_q    <= trig_mode;
                trig_ch_q <= trig_ch;
                level_q   <= trig_level;
                count_q   <= sample_count;
                overrun   <= 1'b0;
                set_cnt   <= '0;
                burst_cnt <= '0;
                ch_idx    <= '0;
            end

            // Timestamp taken is the value before this edge's increment.
            if (take_set) begin
                snap_data <= data_in;
                snap_ts   <= ts_q;
                ch_idx    <= '0;
            end

            // A set arriving while the previous one is still draining is lost.
            if ((state == S_EMIT) && strobe) overrun <= 1'b1;

            if (emit) begin
                data_out      <= word;
                write_fifo_en <= 1'b1;
                if (burst_cnt == BW'(BURST - 1)) begin
                    write_SRAM_en <= 1'b1;
                    burst_cnt     <= '0;
                end else begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
                if (last_ch) begin
                    ch_idx  <= '0;
                    set_cnt <= set_next;
                end else begin
                    ch_idx <= ch_idx + CH_W'(1);
                end
            end

            // Partial burst left over at the end gets its own SRAM request.
            if ((state == S_FLUSH) && (burst_cnt != '0)) begin
                write_SRAM_en <= 1'b1;
                burst_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_acq_write_control.sv
// ---------------------------------------------------------------------------
// tb_acq_write_control
// Directed bench: DUT A uses the default geometry (4 channels, burst 4,
// 32-bit timestamp); DUT B uses 3 channels with an 8-bit timestamp to cover
// the partial-burst flush and timestamp wrap.
// ---------------------------------------------------------------------------
module tb_acq_write_control;
    import acq_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic rst;
    int   r;    // cyc value when reset was released

    // DUT A signals
    logic        a_wr_en, a_new_data, a_full;
    logic [1:0]  a_mode, a_trig_ch;
    logic [11:0] a_level;
    logic [15:0] a_count;
    logic [47:0] a_data_in;
    logic [63:0] a_dout;
    logic        a_wf, a_ws, a_end, a_ovr;

    // DUT B signals
    logic        b_wr_en, b_new_data, b_full;
    logic [1:0]  b_mode, b_trig_ch;
    logic [11:0] b_level;
    logic [15:0] b_count;
    logic [35:0] b_data_in;
    logic [63:0] b_dout;
    logic        b_wf, b_ws, b_end, b_ovr;

    acq_write_control #(.DATA_W(12), .N_CH(4), .TS_W(32), .BURST(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .trig_mode(a_mode), .trig_ch(a_trig_ch),
        .trig_level(a_level), .sample_count(a_count), .new_data(a_new_data),
        .data_in(a_data_in), .fifo_full(a_full), .data_out(a_dout),
        .write_fifo_en(a_wf), .write_SRAM_en(a_ws), .write_end(a_end), .overrun(a_ovr)
    );

    acq_write_control #(.DATA_W(12), .N_CH(3), .TS_W(8), .BURST(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .trig_mode(b_mode), .trig_ch(b_trig_ch),
        .trig_level(b_level), .sample_count(b_count), .new_data(b_new_data),
        .data_in(b_data_in), .fifo_full(b_full), .data_out(b_dout),
        .write_fifo_en(b_wf), .write_SRAM_en(b_ws), .write_end(b_end), .overrun(b_ovr)
    );

    // scoreboard: observed words, their cycle, SRAM requests
    logic [63:0] a_words[$];
    int          a_word_cyc[$];
    int          a_sram_idx[$];   // 1-based word count at which SRAM req came with a word
    int          a_lone = 0;      // SRAM requests without a word (flush)
    logic [63:0] b_words[$];
    int          b_sram_idx[$];
    int          b_lone = 0;

    always @(negedge clk) begin
        if (a_wf) begin
            a_words.push_back(a_dout);
            a_word_cyc.push_back(cyc);
        end
        if (a_ws) begin
            if (a_wf) a_sram_idx.push_back(a_words.size());
            else      a_lone = a_lone + 1;
        end
        if (b_wf) b_words.push_back(b_dout);
        if (b_ws) begin
            if (b_wf) b_sram_idx.push_back(b_words.size());
            else      b_lone = b_lone + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int ts, input int ch, input logic [11:0] s);
        logic [31:0] t;
        logic [7:0]  c;
        t = ts;
        c = 8'(ch);
        return {t, c, 12'h000, s};
    endfunction

    function automatic logic [47:0] set_a(input logic [7:0] tag);
        logic [47:0] d;
        for (int c = 0; c < 4; c++) d[c*12 +: 12] = {tag, 4'(c)};
        return d;
    endfunction

    function automatic logic [63:0] aw(input int i);
        return (i < a_words.size()) ? a_words[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int acyc(input int i);
        return (i < a_word_cyc.size()) ? a_word_cyc[i] : -1;
    endfunction

    function automatic int asram(input int i);
        return (i < a_sram_idx.size()) ? a_sram_idx[i] : -1;
    endfunction

    // driver tasks: inputs change 1 time unit after the falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic strobe_a(input logic [47:0] d, output int k);
        a_data_in  = d;
        a_new_data = 1'b1;
        k          = cyc;   // strobe sampled at edge k+1, timestamp k-r
        tick(1);
        a_new_data = 1'b0;
    endtask

    task automatic wait_a_end(input string name);
        int n;
        n = 0;
        while (!a_end && n < 200) begin
            tick(1);
            n++;
        end
        chk(name, 64'(a_end), 64'd1);
    endtask

    typedef struct {
        logic        arm;
        logic [1:0]  mode;
        logic [11:0] ch2;
        int          exp_words;
    } trig_vec_t;

    trig_vec_t   tv[12];
    logic [47:0] d;
    logic [47:0] sd[2];
    int          ks[2];
    int          k, wb, sb, lb;
    logic [35:0] bd;

    initial begin
        // rising: first strobe primes only, fires on 0x800
        tv[0]  = '{1'b1, TRIG_RISE, 12'h700, 0};
        tv[1]  = '{1'b0, TRIG_RISE, 12'h7FF, 0};
        tv[2]  = '{1'b0, TRIG_RISE, 12'h800, 4};
        // rising: already above level at arm, must see it go below first
        tv[3]  = '{1'b1, TRIG_RISE, 12'h900, 0};
        tv[4]  = '{1'b0, TRIG_RISE, 12'h900, 0};
        tv[5]  = '{1'b0, TRIG_RISE, 12'h7FF, 0};
        tv[6]  = '{1'b0, TRIG_RISE, 12'h800, 4};
        // falling: 0x801 is not <= level, 0x800 is
        tv[7]  = '{1'b1, TRIG_FALL, 12'h900, 0};
        tv[8]  = '{1'b0, TRIG_FALL, 12'h801, 0};
        tv[9]  = '{1'b0, TRIG_FALL, 12'h800, 4};
        // either edge: falling crossing fires
        tv[10] = '{1'b1, TRIG_BOTH, 12'h900, 0};
        tv[11] = '{1'b0, TRIG_BOTH, 12'h700, 4};

        rst = 1'b0;
        a_wr_en = 0; a_new_data = 0; a_full = 0; a_mode = TRIG_IMM; a_trig_ch = 0;
        a_level = 0; a_count = 0; a_data_in = '0;
        b_wr_en = 0; b_new_data = 0; b_full = 0; b_mode = TRIG_IMM; b_trig_ch = 0;
        b_level = 0; b_count = 0; b_data_in = '0;
        tick(3);
        chk("rst_dout", a_dout, 64'd0);
        chk("rst_flags", {60'd0, a_wf, a_ws, a_end, a_ovr}, 64'd0);
        rst = 1'b1;
        r   = cyc;
        tick(2);

        // ---- immediate, 2 sets, strobes 10 cycles apart ----
        wb = a_words.size(); sb = a_sram_idx.size(); lb = a_lone;
        a_mode = TRIG_IMM; a_count = 2; a_wr_en = 1'b1;
        tick(2);
        for (int s = 0; s < 2; s++) begin
            d     = set_a(8'(8'h10 + s));
            sd[s] = d;
            strobe_a(d, ks[s]);
            tick(9);
        end
        wait_a_end("imm_end");
        chk("imm_nwords", 64'(a_words.size() - wb), 64'd8);
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("imm_w%0d", s*4 + c), aw(wb + s*4 + c),
                    mk(ks[s] - r, c, sd[s][c*12 +: 12]));
        chk("imm_latency", 64'(acyc(wb)), 64'(ks[0] + 2));
        chk("imm_sram_n", 64'(a_sram_idx.size() - sb), 64'd2);
        chk("imm_sram_w4", 64'(asram(sb)), 64'(wb + 4));
        chk("imm_sram_w8", 64'(asram(sb + 1)), 64'(wb + 8));
        chk("imm_no_flush", 64'(a_lone - lb), 64'd0);
        chk("imm_ovr", 64'(a_ovr), 64'd0);
        a_wr_en = 1'b0;
        tick(1);
        chk("imm_end_clr", 64'(a_end), 64'd0);

        // ---- trigger table ----
        for (int i = 0; i < 12; i++) begin
            if (tv[i].arm) begin
                a_wr_en = 1'b0;
                tick(2);
                wb = a_words.size(); sb = a_sram_idx.size(); lb = a_lone;
                a_mode = tv[i].mode; a_count = 1; a_trig_ch = 2'd2; a_level = 12'h800;
                a_wr_en = 1'b1;
                tick(2);
            end
            d = set_a(8'(8'h20 + i));
            d[2*12 +: 12] = tv[i].ch2;
            strobe_a(d, k);
            tick(9);
            chk($sformatf("trig%0d_nwords", i), 64'(a_words.size() - wb), 64'(tv[i].exp_words));
            if (tv[i].exp_words == 4) begin
                for (int c = 0; c < 4; c++)
                    chk($sformatf("trig%0d_w%0d", i, c), aw(wb + c), mk(k - r, c, d[c*12 +: 12]));
                chk($sformatf("trig%0d_sram", i), 64'(asram(sb)), 64'(wb + 4));
                chk($sformatf("trig%0d_end", i), 64'(a_end), 64'd1);
            end
        end
        a_wr_en = 1'b0;
        tick(2);

        // ---- overrun and backpressure ----
        wb = a_words.size(); sb = a_sram_idx.size(); lb = a_lone;
        a_mode = TRIG_IMM; a_count = 2; a_wr_en = 1'b1;
        tick(2);
        sd[0] = set_a(8'h30);
        strobe_a(sd[0], ks[0]);
        tick(1);
        strobe_a(set_a(8'h31), k);       // 2 cycles after the first: dropped
        tick(8);
        sd[1] = set_a(8'h32);
        strobe_a(sd[1], ks[1]);
        tick(1);
        a_full = 1'b1;                   // stall after channel 0
        tick(3);
        a_full = 1'b0;
        wait_a_end("bp_end");
        chk("bp_overrun", 64'(a_ovr), 64'd1);
        chk("bp_nwords", 64'(a_words.size() - wb), 64'd8);
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("bp_w%0d", s*4 + c), aw(wb + s*4 + c),
                    mk(ks[s] - r, c, sd[s][c*12 +: 12]));
        chk("bp_stall_cyc", 64'(acyc(wb + 5)), 64'(ks[1] + 6));
        chk("bp_sram_w8", 64'(asram(sb + 1)), 64'(wb + 8));
        chk("bp_no_flush", 64'(a_lone - lb), 64'd0);
        a_wr_en = 1'b0;
        tick(2);

        // ---- abort in TRIGGER, then sample_count 0 ----
        wb = a_words.size(); sb = a_sram_idx.size(); lb = a_lone;
        a_mode = TRIG_RISE; a_count = 3; a_wr_en = 1'b1;
        tick(2);
        strobe_a(set_a(8'h40), k);
        tick(3);
        a_wr_en = 1'b0;
        tick(3);
        chk("abort_nwords", 64'(a_words.size() - wb), 64'd0);
        chk("abort_sram", 64'(a_sram_idx.size() - sb + a_lone - lb), 64'd0);
        chk("abort_end", 64'(a_end), 64'd0);
        a_count = 0; a_wr_en = 1'b1;
        tick(1);
        chk("cnt0_end", 64'(a_end), 64'd1);
        tick(3);
        chk("cnt0_nwords", 64'(a_words.size() - wb), 64'd0);
        chk("cnt0_sram", 64'(a_sram_idx.size() - sb + a_lone - lb), 64'd0);
        a_wr_en = 1'b0;
        tick(2);

        // ---- reset mid-EMIT ----
        wb = a_words.size(); lb = a_lone;
        a_mode = TRIG_IMM; a_count = 2; a_wr_en = 1'b1;
        tick(2);
        strobe_a(set_a(8'h50), k);
        tick(1);
        strobe_a(set_a(8'h51), k);       // lands in EMIT: overrun
        chk("rstm_ovr_set", 64'(a_ovr), 64'd1);
        rst = 1'b0; a_wr_en = 1'b0;
        tick(1);
        chk("rstm_dout", a_dout, 64'd0);
        chk("rstm_flags", {60'd0, a_wf, a_ws, a_end, a_ovr}, 64'd0);
        chk("rstm_nwords", 64'(a_words.size() - wb), 64'd2);
        tick(2);
        rst = 1'b1;
        r   = cyc;
        tick(4);
        chk("rstm_no_flush", 64'(a_lone - lb + a_words.size() - wb), 64'd2);
        wb = a_words.size();
        a_count = 1; a_wr_en = 1'b1;
        tick(2);
        d = set_a(8'h52);
        strobe_a(d, k);
        tick(9);
        chk("rstm_ts_restart", aw(wb), mk(k - r, 0, d[11:0]));
        chk("rstm_w3", aw(wb + 3), mk(k - r, 3, d[47:36]));
        a_wr_en = 1'b0;
        tick(2);

        // ---- DUT B: 3 channels, partial burst flush, 8-bit timestamp wrap ----
        while (cyc - r < 300) tick(1);
        b_mode = TRIG_IMM; b_count = 1; b_wr_en = 1'b1;
        tick(2);
        bd = {12'hC02, 12'hB01, 12'hA00};
        b_data_in  = bd;
        b_new_data = 1'b1;
        k = cyc;
        tick(1);
        b_new_data = 1'b0;
        tick(9);
        chk("b_nwords", 64'(b_words.size()), 64'd3);
        for (int c = 0; c < 3; c++)
            chk($sformatf("b_w%0d", c), (c < b_words.size()) ? b_words[c] : 64'hFFFF_FFFF_FFFF_FFFF,
                mk((k - r) % 256, c, bd[c*12 +: 12]));
        chk("b_sram_with_word", 64'(b_sram_idx.size()), 64'd0);
        chk("b_flush", 64'(b_lone), 64'd1);
        chk("b_end", 64'(b_end), 64'd1);
        chk("b_ovr", 64'(b_ovr), 64'd0);
        b_wr_en = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
